// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared opcode encodings, widths and the decoded control bundle for the pipeline controller.
package pipe_ctrl_unit_pkg;

  localparam int OPW_DEF      = 4;
  localparam int REGW_DEF     = 4;
  localparam int LINK_REG_DEF = 15;

  localparam logic [OPW_DEF-1:0] OP_SLL = 4'b0100;
  localparam logic [OPW_DEF-1:0] OP_SRL = 4'b0101;
  localparam logic [OPW_DEF-1:0] OP_LW  = 4'b1000;
  localparam logic [OPW_DEF-1:0] OP_SW  = 4'b1001;
  localparam logic [OPW_DEF-1:0] OP_BEQ = 4'b1010;
  localparam logic [OPW_DEF-1:0] OP_J   = 4'b1011;
  localparam logic [OPW_DEF-1:0] OP_JR  = 4'b1100;
  localparam logic [OPW_DEF-1:0] OP_JAL = 4'b1101;
  localparam logic [OPW_DEF-1:0] OP_IL0 = 4'b1110;
  localparam logic [OPW_DEF-1:0] OP_IL1 = 4'b1111;

  typedef struct packed {
    logic                wen;
    logic [OPW_DEF-1:0]  aluop;
    logic                alusrc;
    logic                regdst;
    logic                branch;
    logic                jump;
    logic                jr;
    logic                jal;
    logic                read;
    logic                write;
    logic                sel_mem;
    logic [REGW_DEF-1:0] dst;
  } ctrl_bundle_t;

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// ID-stage opcode decoder: opcode -> control bundle plus which source fields are read.
module ctrl_decode
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic [OPW_DEF-1:0]  opcode,
  input  logic [REGW_DEF-1:0] rd,
  output ctrl_bundle_t        ctrl,
  output logic                use_rs,
  output logic                use_rt,
  output logic                use_rd
);

  // decode the opcode; r0 destinations never write
  always_comb begin
    ctrl       = '0;
    ctrl.wen   = 1'b1;
    ctrl.aluop = opcode;
    ctrl.dst   = rd;
    case (opcode)
      OP_LW: begin
        ctrl.alusrc  = 1'b1;
        ctrl.read    = 1'b1;
        ctrl.sel_mem = 1'b1;
      end
      OP_SW: begin
        ctrl.wen    = 1'b0;
        ctrl.alusrc = 1'b1;
        ctrl.write  = 1'b1;
        ctrl.regdst = 1'b1;
      end
      OP_SLL, OP_SRL: ctrl.alusrc = 1'b1;
      OP_BEQ: begin
        ctrl.wen    = 1'b0;
        ctrl.branch = 1'b1;
        ctrl.regdst = 1'b1;
      end
      OP_J: begin
        ctrl.wen  = 1'b0;
        ctrl.jump = 1'b1;
      end
      OP_JR: begin
        ctrl.wen = 1'b0;
        ctrl.jr  = 1'b1;
      end
      OP_JAL: begin
        ctrl.jr  = 1'b1;
        ctrl.jal = 1'b1;
        ctrl.dst = REGW_DEF'(LINK_REG);
      end
      OP_IL0, OP_IL1: ctrl.wen = 1'b0;
      default: ;
    endcase
    if (ctrl.dst == '0) ctrl.wen = 1'b0;
  end

  // second source is rd for regdst ops, rt for register-register ops, none for immediates
  always_comb begin
    use_rs = (opcode != OP_J);
    use_rd = ctrl.regdst;
    use_rt = !ctrl.regdst && !ctrl.alusrc;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: ID decode, load-use stall, branch/jump flush, ID/EX, EX/MEM, MEM/WB
// control registers and saturating stall/flush counters.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int OPW      = OPW_DEF,
  parameter int REGW     = REGW_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_opcode,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic            ex_br_taken,
  output logic            stall,
  output logic            flush_ifid,
  output logic            ex_valid,
  output logic [OPW-1:0]  ex_aluop,
  output logic            ex_alusrc,
  output logic            ex_regdst,
  output logic            ex_branch,
  output logic [REGW-1:0] ex_dst,
  output logic            mem_valid,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_wen,
  output logic [REGW-1:0] mem_dst,
  output logic            wb_valid,
  output logic            wb_wen,
  output logic            wb_sel_mem,
  output logic            wb_jal,
  output logic [REGW-1:0] wb_dst,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  ctrl_bundle_t id_ctrl;
  logic         use_rs, use_rt, use_rd;
  logic         ex_wen, ex_read, ex_write, ex_sel_mem, ex_jal;
  logic         mem_sel_mem, mem_jal;
  logic         br_flush, jmp_flush, src_match, ex_bubble;

  ctrl_decode #(.LINK_REG(LINK_REG)) u_decode (
    .opcode (id_opcode),
    .rd     (id_rd),
    .ctrl   (id_ctrl),
    .use_rs (use_rs),
    .use_rt (use_rt),
    .use_rd (use_rd)
  );

  // hazard and flush resolution: EX branch beats load-use stall beats ID jump
  always_comb begin
    src_match  = (use_rs && id_rs == ex_dst) || (use_rt && id_rt == ex_dst) ||
                 (use_rd && id_rd == ex_dst);
    br_flush   = !rst && ex_valid && ex_branch && ex_br_taken;
    stall      = !rst && !br_flush && id_valid && ex_valid && ex_read &&
                 (ex_dst != '0) && !ex_br_taken && src_match;
    jmp_flush  = !rst && !br_flush && !stall && id_valid &&
                 (id_ctrl.jump || id_ctrl.jr || id_ctrl.jal);
    flush_ifid = br_flush || jmp_flush;
    ex_bubble  = br_flush || stall || !id_valid;
  end

  // ID/EX register: a squashed, stalled or empty slot becomes an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || ex_bubble) begin
      ex_valid   <= 1'b0;
      ex_aluop   <= '0;
      ex_alusrc  <= 1'b0;
      ex_regdst  <= 1'b0;
      ex_branch  <= 1'b0;
      ex_dst     <= '0;
      ex_wen     <= 1'b0;
      ex_read    <= 1'b0;
      ex_write   <= 1'b0;
      ex_sel_mem <= 1'b0;
      ex_jal     <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_aluop   <= id_ctrl.aluop;
      ex_alusrc  <= id_ctrl.alusrc;
      ex_regdst  <= id_ctrl.regdst;
      ex_branch  <= id_ctrl.branch;
      ex_dst     <= id_ctrl.dst;
      ex_wen     <= id_ctrl.wen;
      ex_read    <= id_ctrl.read;
      ex_write   <= id_ctrl.write;
      ex_sel_mem <= id_ctrl.sel_mem;
      ex_jal     <= id_ctrl.jal;
    end
  end

  // EX/MEM and MEM/WB registers advance unconditionally
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wen     <= 1'b0;
      mem_dst     <= '0;
      mem_sel_mem <= 1'b0;
      mem_jal     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_wen      <= 1'b0;
      wb_sel_mem  <= 1'b0;
      wb_jal      <= 1'b0;
      wb_dst      <= '0;
    end else begin
      mem_valid   <= ex_valid;
      mem_read    <= ex_read;
      mem_write   <= ex_write;
      mem_wen     <= ex_wen;
      mem_dst     <= ex_dst;
      mem_sel_mem <= ex_sel_mem;
      mem_jal     <= ex_jal;
      wb_valid    <= mem_valid;
      wb_wen      <= mem_wen;
      wb_sel_mem  <= mem_sel_mem;
      wb_jal      <= mem_jal;
      wb_dst      <= mem_dst;
    end
  end

  // saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ifid && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios then random traffic, each cycle checked
// against a rule-level reference model of decode, hazards and pipeline shifting.
module tb_pipe_ctrl_unit;

  localparam logic [3:0] ADD = 4'b0000, SLL = 4'b0100, SRL = 4'b0101, LW = 4'b1000,
                         SW = 4'b1001, BEQ = 4'b1010, J = 4'b1011, JR = 4'b1100,
                         JAL = 4'b1101;

  logic clk = 1'b0;
  logic rst, id_valid, ex_br_taken;
  logic [3:0] id_opcode, id_rs, id_rt, id_rd;

  logic stall, flush_ifid, ex_valid, ex_alusrc, ex_regdst, ex_branch;
  logic [3:0] ex_aluop, ex_dst, mem_dst, wb_dst;
  logic mem_valid, mem_read, mem_write, mem_wen;
  logic wb_valid, wb_wen, wb_sel_mem, wb_jal;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_stall, s_flush, s_ex_valid, s_ex_alusrc, s_ex_regdst, s_ex_branch;
  logic [3:0] s_ex_aluop, s_ex_dst, s_mem_dst, s_wb_dst;
  logic s_mem_valid, s_mem_read, s_mem_write, s_mem_wen;
  logic s_wb_valid, s_wb_wen, s_wb_sel_mem, s_wb_jal;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken), .stall(stall),
    .flush_ifid(flush_ifid), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_dst(ex_dst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_wen(mem_wen),
    .mem_dst(mem_dst), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_sel_mem(wb_sel_mem),
    .wb_jal(wb_jal), .wb_dst(wb_dst), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_unit #(.CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken), .stall(s_stall),
    .flush_ifid(s_flush), .ex_valid(s_ex_valid), .ex_aluop(s_ex_aluop),
    .ex_alusrc(s_ex_alusrc), .ex_regdst(s_ex_regdst), .ex_branch(s_ex_branch),
    .ex_dst(s_ex_dst), .mem_valid(s_mem_valid), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .mem_wen(s_mem_wen), .mem_dst(s_mem_dst),
    .wb_valid(s_wb_valid), .wb_wen(s_wb_wen), .wb_sel_mem(s_wb_sel_mem),
    .wb_jal(s_wb_jal), .wb_dst(s_wb_dst), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct packed {
    logic valid, wen, alusrc, regdst, branch, read, write, sel_mem, jal, jmp;
    logic use_rs, use_rt, use_rd;
    logic [3:0] aluop, dst;
  } ref_t;

  ref_t m_ex, m_mem, m_wb;
  int unsigned n_stall, n_flush;
  logic last_stall;
  int vec = 0;
  int errs = 0;

  // instruction meaning written as set membership over the opcode table
  function automatic ref_t ref_decode(logic [3:0] op, logic [3:0] rd);
    ref_t r;
    r         = '0;
    r.valid   = 1'b1;
    r.aluop   = op;
    r.dst     = (op == JAL) ? 4'd15 : rd;
    r.wen     = !(op inside {SW, BEQ, J, JR, 4'b1110, 4'b1111}) && (r.dst != 4'd0);
    r.alusrc  = op inside {LW, SW, SLL, SRL};
    r.regdst  = op inside {SW, BEQ};
    r.branch  = (op == BEQ);
    r.read    = (op == LW);
    r.write   = (op == SW);
    r.sel_mem = (op == LW);
    r.jal     = (op == JAL);
    r.jmp     = op inside {J, JR, JAL};
    r.use_rs  = (op != J);
    r.use_rd  = r.regdst;
    r.use_rt  = !r.regdst && !r.alusrc;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [3:0] op, logic [3:0] rs, logic [3:0] rt,
                       logic [3:0] rd, logic bt);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = bt;
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    ref_t d;
    logic br, st, jf, hit;
    int unsigned sat16, sat2;
    #1;
    d   = ref_decode(id_opcode, id_rd);
    hit = (d.use_rs && id_rs == m_ex.dst) || (d.use_rt && id_rt == m_ex.dst) ||
          (d.use_rd && id_rd == m_ex.dst);
    br  = !rst && m_ex.valid && m_ex.branch && ex_br_taken;
    st  = !rst && !br && id_valid && m_ex.valid && m_ex.read && (m_ex.dst != 4'd0) &&
          !ex_br_taken && hit;
    jf  = !rst && !br && !st && id_valid && d.jmp;
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, br | jf});
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; n_stall = 0; n_flush = 0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (br || st || !id_valid) ? '0 : d;
      if (st) n_stall++;
      if (br || jf) n_flush++;
    end
    last_stall = st;
    @(posedge clk);
    #1;
    chk("ex_bundle", {20'd0, ex_valid, ex_aluop, ex_alusrc, ex_regdst, ex_branch, ex_dst},
        {20'd0, m_ex.valid, m_ex.aluop, m_ex.alusrc, m_ex.regdst, m_ex.branch, m_ex.dst});
    chk("mem_bundle", {24'd0, mem_valid, mem_read, mem_write, mem_wen, mem_dst},
        {24'd0, m_mem.valid, m_mem.read, m_mem.write, m_mem.wen, m_mem.dst});
    chk("wb_bundle", {24'd0, wb_valid, wb_wen, wb_sel_mem, wb_jal, wb_dst},
        {24'd0, m_wb.valid, m_wb.wen, m_wb.sel_mem, m_wb.jal, m_wb.dst});
    sat16 = (n_stall > 65535) ? 65535 : n_stall;
    chk("stall_cnt", {16'd0, stall_cnt}, sat16);
    sat16 = (n_flush > 65535) ? 65535 : n_flush;
    chk("flush_cnt", {16'd0, flush_cnt}, sat16);
    sat2 = (n_stall > 3) ? 3 : n_stall;
    chk("sat_stall_cnt", {30'd0, s_stall_cnt}, sat2);
    sat2 = (n_flush > 3) ? 3 : n_flush;
    chk("sat_flush_cnt", {30'd0, s_flush_cnt}, sat2);
  endtask

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0; n_stall = 0; n_flush = 0; last_stall = 1'b0;

    // reset with a random opcode in ID
    rst = 1'b1;
    drive(1'b1, 4'($urandom), 4'd1, 4'd2, 4'd3, 1'b0);
    step();
    step();
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;

    // independent ADDs: no stall, dst 3 walks EX/MEM/WB
    drive(1'b1, ADD, 4'd1, 4'd2, 4'd3, 1'b0); step();
    chk("add_ex_dst", {28'd0, ex_dst}, 32'd3);
    drive(1'b1, ADD, 4'd3, 4'd5, 4'd4, 1'b0); step();
    chk("add_mem_dst", {28'd0, mem_dst}, 32'd3);
    drive(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0); step();
    chk("add_wb_dst", {28'd0, wb_dst}, 32'd3);
    step();

    // load-use: one stall cycle, bubble in EX, ADD enters on the retry
    drive(1'b1, LW, 4'd1, 4'd0, 4'd2, 1'b0); step();
    drive(1'b1, ADD, 4'd2, 4'd1, 4'd6, 1'b0); step();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    step();
    chk("lu_add_in_ex", {28'd0, ex_dst}, 32'd6);
    drive(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0); step(); step(); step();

    // load to r0 never stalls and never writes back
    drive(1'b1, LW, 4'd1, 4'd0, 4'd0, 1'b0); step();
    drive(1'b1, ADD, 4'd0, 4'd1, 4'd6, 1'b0); step();
    drive(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0); step();
    chk("lw_r0_wb", {30'd0, wb_valid, wb_wen}, 32'b10);
    step(); step();

    // taken BEQ in EX squashes a J in ID; then a non-branch in EX ignores br_taken
    drive(1'b1, BEQ, 4'd1, 4'd0, 4'd2, 1'b0); step();
    drive(1'b1, J, 4'd0, 4'd0, 4'd0, 1'b1); step();
    chk("br_bubble", {31'd0, ex_valid}, 32'd0);
    drive(1'b1, ADD, 4'd1, 4'd2, 4'd7, 1'b0); step();
    drive(1'b1, J, 4'd0, 4'd0, 4'd0, 1'b1); step();
    drive(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0); step(); step(); step();

    // JAL: writes the link register three cycles later
    drive(1'b1, JAL, 4'd1, 4'd2, 4'd3, 1'b0); step();
    drive(1'b0, ADD, 4'd0, 4'd0, 4'd0, 1'b0); step(); step();
    chk("jal_wb", {25'd0, wb_jal, wb_wen, 1'b0, wb_dst}, {25'd0, 1'b1, 1'b1, 1'b0, 4'd15});

    // five more load-use stalls to drive the narrow counter into saturation
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, LW, 4'd1, 4'd0, 4'd2, 1'b0); step();
      drive(1'b1, SW, 4'd2, 4'd0, 4'd5, 1'b0); step();
      drive(1'b1, ADD, 4'd2, 4'd2, 4'd6, 1'b0); step(); step();
    end
    chk("sat_final", {30'd0, s_stall_cnt}, 32'd3);

    // random traffic; IF/ID is held while the model predicts a stall
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!last_stall) begin
        id_valid    = ($urandom_range(0, 7) != 0);
        id_opcode   = ($urandom_range(0, 2) == 0) ? LW : 4'($urandom);
        id_rs       = 4'($urandom_range(0, 3));
        id_rt       = 4'($urandom_range(0, 3));
        id_rd       = 4'($urandom_range(0, 3));
      end
      ex_br_taken = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
